ad_capture_packer: RTL and testbench
====================================

// Module: ad_capture_packer
// PURPOSE
//  Front-end sampler for the 16-bit parallel multi-channel ADC; sits directly upstream of the dual-clock
//  sample FIFO (write side, clk_50_0 domain). Resets the ADC, paces conversions, reads NUM_CH channels
//  per frame via CS/RD strobes, packs channel pairs into 32-bit words and pushes them into the FIFO.
// PARAMETERS
//  NUM_CH       8    channels read per conversion frame; must be even, 2..8
//  RST_CYCLES   10   cycles ad_reset is held high after reset release or resync
//  CONV_PERIOD  250  cycles between ad_convst rising edges (50 MHz / 250 = 200 kSPS)
//  CONVST_LOW   4    cycles ad_convst is held low per conversion
//  RD_LOW       2    cycles ad_rd_n low per channel; data sampled on the last low cycle
//  RD_HIGH      2    cycles ad_rd_n high between channels
//  BUSY_TO      200  max cycles in WAIT_BUSY before timeout
// PORTS
//  clk          in   1   sampling clock (clk_50_0 domain)
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   level; 1 = run conversions, 0 = stop after current frame
//  ad_data      in   16  ADC parallel data bus
//  ad_busy      in   1   ADC busy, high during conversion
//  first_data   in   1   ADC marker, high while channel 0 is on the bus
//  ad_reset     out  1   ADC reset, active high
//  ad_convst    out  1   ADC conversion start, rising edge starts conversion
//  ad_cs_n      out  1   ADC chip select, active low, low for whole read phase
//  ad_rd_n      out  1   ADC read strobe, active low
//  data_flag    out  1   1-cycle pulse per captured sample
//  fifo_full    in   1   sample FIFO full (write side)
//  fifo_wrreq   out  1   1-cycle FIFO write request
//  fifo_data    out  32  packed word: {earlier channel, later channel}
//  overflow     out  1   sticky: a word was dropped because fifo_full
//  sync_err     out  1   sticky: first_data missing at ch0 or busy timeout
// BEHAVIOUR
//  Reset values: ad_reset=1, ad_convst=1, ad_cs_n=1, ad_rd_n=1, all other outputs 0; FSM=AD_RST.
//  Reset mid-operation: all outputs return to reset values immediately (async); partial word discarded.
//  FSM: AD_RST -> IDLE -> CONVST -> WAIT_BUSY -> READ -> IDLE.
//   AD_RST: ad_reset=1 for RST_CYCLES cycles, then 0, go IDLE.
//   IDLE: when start=1 and period timer expired (or first conversion), go CONVST, restart timer.
//   CONVST: ad_convst=0 for CONVST_LOW cycles, then 1; go WAIT_BUSY.
//   WAIT_BUSY: wait for ad_busy rise then fall (registered input); fall -> READ.
//    BUSY_TO cycles without completing -> sync_err=1, go AD_RST.
//   READ: ad_cs_n=0; per channel ad_rd_n low RD_LOW, high RD_HIGH; ad_data latched on last low cycle,
//    data_flag pulses that cycle. At ch0 first_data must be 1, else sync_err=1, frame dropped, go AD_RST.
//    After last channel: ad_cs_n=1, go IDLE.
//  Packing: even channel -> fifo_data[31:16], next odd channel -> [15:0]; fifo_wrreq pulses one cycle
//   after odd-channel capture, fifo_data valid the same cycle. NUM_CH/2 writes per frame.
//  fifo_full=1 at write cycle: fifo_wrreq stays 0, word dropped, overflow=1 (sticky until reset).
//  Period timer counts 0..CONV_PERIOD-1 and wraps; if frame still reading when it wraps, next CONVST
//   issues on return to IDLE (no conversion overlap, no catch-up).
//  start falls mid-frame: frame completes fully, then stays IDLE. ad_data treated as raw 16-bit; no sign math.
// CONFIGURATION
//  TEST_PATTERN_EN defined: ad_data ignored; captured sample = 16-bit counter incremented per sample,
//   wrapping 0xFFFF->0x0000, reset to 0; ADC handshake timing unchanged. Undefined: real ad_data captured.
// STRUCTURE
//  Package ad_pkg: FSM state encoding constants, DATA_W=16, WORD_W=32.
//  One sub-module: ad_rd_timer (CS/RD strobe sequencer with channel index + capture strobe).
// TESTING
//  Reset release -> ad_reset high exactly 10 cycles, then ad_convst pulses low 4 cycles with start=1.
//  ADC model, NUM_CH=8, data=ch*0x1111 -> 4 writes 0x00001111, 0x22223333, 0x44445555, 0x66667777.
//  fifo_full=1 during 2nd write -> that word absent, other 3 written, overflow=1 until reset.
//  first_data=0 at ch0 -> no fifo_wrreq that frame, sync_err=1, ad_reset re-pulsed 10 cycles.
//  ad_busy never falls -> after 200 cycles sync_err=1 and AD_RST entered.
//  start dropped during ch3 read -> remaining 4 channels read, then no further ad_convst.

Source files
------------

// File: rtl/ad_pkg.sv
// ad_pkg: shared definitions for the ADC capture front end.
//   ad_state_t : capture FSM states
//   DATA_W     : ADC sample width
//   WORD_W     : packed FIFO word width (two samples)
//   max3       : helper for sizing shared counters
package ad_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        AD_RST    = 3'd0,
        IDLE      = 3'd1,
        CONVST    = 3'd2,
        WAIT_BUSY = 3'd3,
        READ      = 3'd4
    } ad_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ad_rd_timer.sv
// ad_rd_timer: CS/RD strobe sequencer for the read phase of one frame.
//   clk, reset : clock, asynchronous active-low reset
//   run        : high while the read phase is active; low clears the sequence
//   rd_n       : ADC read strobe, low for RD_LOW cycles then high for RD_HIGH per channel
//   ch         : index of the channel currently being read
//   capture    : high on the last low cycle of rd_n (sample point)
//   done       : high on the final cycle of the last channel
module ad_rd_timer #(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned RD_LOW  = 2,
    parameter int unsigned RD_HIGH = 2,
    parameter int unsigned CH_W    = $clog2(NUM_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            rd_n,
    output logic [CH_W-1:0] ch,
    output logic            capture,
    output logic            done
);

    localparam int unsigned SLOT = RD_LOW + RD_HIGH;
    localparam int unsigned PH_W = $clog2(SLOT + 1);

    logic [PH_W-1:0] phase;
    logic            last_phase;
    logic            last_ch;

    always_comb begin
        last_phase = (phase == PH_W'(SLOT - 1));
        last_ch    = (ch == CH_W'(NUM_CH - 1));
        rd_n       = !(run && (phase < PH_W'(RD_LOW)));
        capture    = run && (phase == PH_W'(RD_LOW - 1));
        done       = run && last_phase && last_ch;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
            ch    <= '0;
        end else if (!run) begin
            phase <= '0;
            ch    <= '0;
        end else if (last_phase) begin
            phase <= '0;
            ch    <= last_ch ? '0 : ch + 1'b1;
        end else begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/ad_capture_packer.sv
// ad_capture_packer: front-end sampler for the 16-bit parallel multi-channel ADC.
// Resets the ADC, paces conversions, reads NUM_CH channels per frame and packs
// channel pairs into 32-bit words for the sample FIFO write side.
//   clk         : sampling clock
//   reset       : asynchronous active-low reset
//   start       : level, 1 = keep converting, 0 = stop after the current frame
//   ad_data     : ADC parallel data bus
//   ad_busy     : ADC busy (high during conversion)
//   first_data  : ADC marker, high while channel 0 is on the bus
//   ad_reset    : ADC reset, active high
//   ad_convst   : ADC conversion start (rising edge starts)
//   ad_cs_n     : ADC chip select, low for the whole read phase
//   ad_rd_n     : ADC read strobe
//   data_flag   : one-cycle pulse per captured sample
//   fifo_full   : sample FIFO full
//   fifo_wrreq  : one-cycle FIFO write request
//   fifo_data   : packed word {earlier channel, later channel}
//   overflow    : sticky, a word was dropped because the FIFO was full
//   sync_err    : sticky, first_data missing at ch0 or busy timeout
// Build option: define TEST_PATTERN_EN to capture a per-sample counter instead
// of ad_data (handshake timing unchanged).
module ad_capture_packer
    import ad_pkg::*;
#(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned RST_CYCLES  = 10,
    parameter int unsigned CONV_PERIOD = 250,
    parameter int unsigned CONVST_LOW  = 4,
    parameter int unsigned RD_LOW      = 2,
    parameter int unsigned RD_HIGH     = 2,
    parameter int unsigned BUSY_TO     = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_busy,
    input  logic              first_data,
    output logic              ad_reset,
    output logic              ad_convst,
    output logic              ad_cs_n,
    output logic              ad_rd_n,
    output logic              data_flag,
    input  logic              fifo_full,
    output logic              fifo_wrreq,
    output logic [WORD_W-1:0] fifo_data,
    output logic              overflow,
    output logic              sync_err
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(max3(RST_CYCLES, CONVST_LOW, BUSY_TO) + 1);
    localparam int unsigned TMR_W = $clog2(CONV_PERIOD + 1);

    ad_state_t         state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [TMR_W-1:0]  tmr;
    logic              pending;
    logic              busy_q, busy_seen, busy_done;
    logic              tmr_wrap;
    logic              rd_run, rd_capture, rd_done;
    logic [CH_W-1:0]   rd_ch;
    logic              marker_bad, good_capture;
    logic [DATA_W-1:0] sample, hi_reg;
    logic              wr_pend;

    ad_rd_timer #(
        .NUM_CH (NUM_CH),
        .RD_LOW (RD_LOW),
        .RD_HIGH(RD_HIGH),
        .CH_W   (CH_W)
    ) u_rd_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (rd_run),
        .rd_n   (ad_rd_n),
        .ch     (rd_ch),
        .capture(rd_capture),
        .done   (rd_done)
    );

`ifdef TEST_PATTERN_EN
    logic [DATA_W-1:0] pat_cnt;
    logic              unused_data;

    assign unused_data = ^ad_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_cnt <= '0;
        end else if (good_capture) begin
            pat_cnt <= pat_cnt + 1'b1;
        end
    end

    always_comb sample = pat_cnt;
`else
    always_comb sample = ad_data;
`endif

    always_comb begin
        tmr_wrap     = (tmr == TMR_W'(CONV_PERIOD - 1));
        busy_done    = busy_seen && !busy_q;
        marker_bad   = rd_capture && (rd_ch == '0) && !first_data;
        good_capture = rd_capture && !marker_bad;
        data_flag    = good_capture;
        fifo_wrreq   = wr_pend && !fifo_full;
    end

    // Next-state and strobe decode
    always_comb begin
        next_state = state;
        ad_reset   = 1'b0;
        ad_convst  = 1'b1;
        ad_cs_n    = 1'b1;
        rd_run     = 1'b0;
        case (state)
            AD_RST: begin
                ad_reset = 1'b1;
                if (cnt == CNT_W'(RST_CYCLES - 1)) next_state = IDLE;
            end
            IDLE: begin
                if (start && (pending || tmr_wrap)) next_state = CONVST;
            end
            CONVST: begin
                ad_convst = 1'b0;
                if (cnt == CNT_W'(CONVST_LOW - 1)) next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_done) next_state = READ;
                else if (cnt == CNT_W'(BUSY_TO - 1)) next_state = AD_RST;
            end
            READ: begin
                ad_cs_n = 1'b0;
                rd_run  = 1'b1;
                if (marker_bad) next_state = AD_RST;
                else if (rd_done) next_state = IDLE;
            end
            default: next_state = AD_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= AD_RST;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
        end
    end

    // Conversion pacing: pending remembers one missed or initial slot so a
    // late frame triggers exactly one conversion on return to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr       <= '0;
            pending   <= 1'b0;
            busy_q    <= 1'b0;
            busy_seen <= 1'b0;
        end else begin
            busy_q    <= ad_busy;
            busy_seen <= (state == WAIT_BUSY) && (busy_seen || busy_q);
            if ((state == IDLE) && (next_state == CONVST)) begin
                tmr     <= '0;
                pending <= 1'b0;
            end else begin
                tmr <= tmr_wrap ? '0 : tmr + 1'b1;
                if (state == AD_RST || tmr_wrap) pending <= 1'b1;
            end
        end
    end

    // Packing and status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg    <= '0;
            fifo_data <= '0;
            wr_pend   <= 1'b0;
            overflow  <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            wr_pend <= good_capture && rd_ch[0];
            if (good_capture) begin
                if (!rd_ch[0]) hi_reg <= sample;
                else           fifo_data <= {hi_reg, sample};
            end
            if (wr_pend && fifo_full) overflow <= 1'b1;
            if (marker_bad ||
                ((state == WAIT_BUSY) && !busy_done && (cnt == CNT_W'(BUSY_TO - 1))))
                sync_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ad_capture_packer.sv
module tb_ad_capture_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] ad_data;
    logic        ad_busy;
    logic        first_data;
    logic        ad_reset;
    logic        ad_convst;
    logic        ad_cs_n;
    logic        ad_rd_n;
    logic        data_flag;
    logic        fifo_full;
    logic        fifo_wrreq;
    logic [31:0] fifo_data;
    logic        overflow;
    logic        sync_err;

    int          tests;
    int          fails;
    int unsigned cyc;
    int unsigned last_conv;
    logic        exp_ovf;
    logic        exp_serr;
    logic [15:0] chd [8];

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ad_capture_packer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ad_data    (ad_data),
        .ad_busy    (ad_busy),
        .first_data (first_data),
        .ad_reset   (ad_reset),
        .ad_convst  (ad_convst),
        .ad_cs_n    (ad_cs_n),
        .ad_rd_n    (ad_rd_n),
        .data_flag  (data_flag),
        .fifo_full  (fifo_full),
        .fifo_wrreq (fifo_wrreq),
        .fifo_data  (fifo_data),
        .overflow   (overflow),
        .sync_err   (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int c = 0; c < 8; c++) chd[c] = 16'($urandom);
    endtask

    // One conversion frame: ADC busy handshake plus read-phase checks.
    // Read-phase cycle i: channel i/4, rd_n low for i%4 in {0,1}, sample at i%4==1,
    // FIFO write for pair k one cycle after odd-channel sample (i == 8k+6).
    task automatic do_frame(input logic [3:0] full_mask, input bit marker_ok,
                            input bit drop_start, input bit chk_period);
        int  n;
        int  k;
        int  ch;
        bit  ok;
        bit  bad;
        bit  wr_slot;

        ok = 0;
        for (int w = 0; w < 600; w++) begin
            tick();
            if (ad_convst === 1'b0) begin ok = 1; break; end
        end
        check("convst_seen", 32'(ok), 1);
        if (!ok) return;
        if (chk_period) check("conv_period", cyc - last_conv, 250);
        last_conv = cyc;

        n = 1;
        for (int w = 0; w < 20; w++) begin
            tick();
            if (ad_convst === 1'b1) break;
            n++;
        end
        check("convst_low_cycles", n, 4);

        repeat ($urandom_range(1, 4)) tick();
        ad_busy = 1'b1;
        repeat ($urandom_range(3, 30)) tick();
        ad_busy = 1'b0;

        ok = 0;
        for (int w = 0; w < 20; w++) begin
            tick();
            if (ad_cs_n === 1'b0) begin ok = 1; break; end
        end
        check("cs_low", 32'(ok), 1);
        if (!ok) return;

        for (int i = 0; i < 32; i++) begin
            if (i > 0) tick();
            k          = i / 8;
            ch         = i / 4;
            ad_data    = chd[ch];
            first_data = (ch == 0) ? marker_ok : 1'b0;
            wr_slot    = (i % 8 == 6);
            fifo_full  = wr_slot ? full_mask[k] : 1'($urandom_range(0, 1));
            if (drop_start && i == 12) start = 1'b0;
            @(negedge clk);
            check("cs_n", 32'(ad_cs_n), 0);
            check("rd_n", 32'(ad_rd_n), 32'(i % 4 >= 2));
            if (marker_ok) check("data_flag", 32'(data_flag), 32'(i % 4 == 1));
            check("wrreq", 32'(fifo_wrreq), 32'(wr_slot && !full_mask[k]));
            if (wr_slot && !full_mask[k]) check("word", fifo_data, {chd[2*k], chd[2*k+1]});
            if (wr_slot && full_mask[k]) exp_ovf = 1'b1;
            if (!marker_ok && i == 1) break;
        end

        tick();
        fifo_full  = 1'b0;
        ad_data    = '0;
        first_data = 1'b0;
        if (marker_ok) begin
            check("cs_end", 32'(ad_cs_n), 1);
            check("overflow", 32'(overflow), 32'(exp_ovf));
            check("sync_err", 32'(sync_err), 32'(exp_serr));
        end else begin
            exp_serr = 1'b1;
            check("resync_ad_reset", 32'(ad_reset), 1);
            check("resync_cs_n", 32'(ad_cs_n), 1);
            check("sync_err_marker", 32'(sync_err), 1);
            n   = 0;
            bad = 0;
            for (int w = 0; w < 30; w++) begin
                tick();
                n++;
                if (fifo_wrreq !== 1'b0) bad = 1;
                if (ad_reset === 1'b0) break;
            end
            check("resync_len", n, 10);
            check("no_wr_bad_frame", 32'(bad), 0);
        end
    endtask

    initial begin
        int  n;
        bit  ok;

        tests      = 0;
        fails      = 0;
        last_conv  = 0;
        exp_ovf    = 1'b0;
        exp_serr   = 1'b0;
        reset      = 1'b0;
        start      = 1'b0;
        ad_busy    = 1'b0;
        ad_data    = '0;
        first_data = 1'b0;
        fifo_full  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ad_reset", 32'(ad_reset), 1);
        check("rst_convst", 32'(ad_convst), 1);
        check("rst_cs_n", 32'(ad_cs_n), 1);
        check("rst_rd_n", 32'(ad_rd_n), 1);
        check("rst_data_flag", 32'(data_flag), 0);
        check("rst_wrreq", 32'(fifo_wrreq), 0);
        check("rst_fifo_data", fifo_data, 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_sync_err", 32'(sync_err), 0);

        start = 1'b1;
        reset = 1'b1;
        n = 0;
        for (int w = 0; w < 40; w++) begin
            tick();
            n++;
            if (ad_reset === 1'b0) break;
        end
        check("ad_reset_len", n, 10);

        // Fixed pattern ch*0x1111
        for (int c = 0; c < 8; c++) chd[c] = 16'(c * 16'h1111);
        do_frame(4'b0000, 1, 0, 0);
        do_frame(4'b0010, 1, 0, 1);

        for (int f = 0; f < 4; f++) begin
            fill_random();
            do_frame(4'($urandom_range(0, 15)), 1, 0, 1);
        end

        fill_random();
        do_frame(4'b0000, 0, 0, 1);
        fill_random();
        do_frame(4'($urandom_range(0, 15)), 1, 0, 0);

        // Asynchronous reset while ad_convst is low
        ok = 0;
        for (int w = 0; w < 400; w++) begin
            tick();
            if (ad_convst === 1'b0) begin ok = 1; break; end
        end
        check("convst_before_reset", 32'(ok), 1);
        reset = 1'b0;
        #1;
        check("async_convst", 32'(ad_convst), 1);
        check("async_ad_reset", 32'(ad_reset), 1);
        check("async_overflow", 32'(overflow), 0);
        check("async_sync_err", 32'(sync_err), 0);
        check("async_fifo_data", fifo_data, 0);
        exp_ovf  = 1'b0;
        exp_serr = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Busy never falls
        ok = 0;
        for (int w = 0; w < 60; w++) begin
            tick();
            if (ad_convst === 1'b0) begin ok = 1; break; end
        end
        check("to_convst_low", 32'(ok), 1);
        ok = 0;
        for (int w = 0; w < 20; w++) begin
            tick();
            if (ad_convst === 1'b1) begin ok = 1; break; end
        end
        check("to_convst_high", 32'(ok), 1);
        check("to_sync_err_before", 32'(sync_err), 0);
        ad_busy = 1'b1;
        n = 0;
        for (int w = 0; w < 300; w++) begin
            tick();
            n++;
            if (ad_reset === 1'b1) break;
        end
        check("busy_timeout_len", n, 200);
        check("to_sync_err_after", 32'(sync_err), 1);
        ad_busy  = 1'b0;
        exp_serr = 1'b1;

        // start dropped during channel 3
        fill_random();
        do_frame(4'b0000, 1, 1, 0);
        n = 0;
        for (int w = 0; w < 600; w++) begin
            tick();
            if (ad_convst !== 1'b1) n++;
        end
        check("no_convst_after_stop", n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
